// File: rtl/sim_uart_fifo.sv
// Simulation UART: a 16550-style byte register window with paced TX/RX FIFOs.
// Host characters move over the putc/getc strobes, which the harness binds to uart_putc/uart_getc.
module sim_uart_fifo #(
  parameter int XLEN     = 64,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TX_DIV   = 1,
  parameter int RX_POLL  = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wen,
  input  logic [7:0]      waddr,
  input  logic [7:0]      wdata,
  input  logic            ren,
  input  logic [7:0]      raddr,
  output logic [XLEN-1:0] rdata,
  output logic            irq,
  // putc_valid/putc_data: the cycle's uart_putc(8'h00, putc_data) call, if any.
  output logic            putc_valid,
  output logic [7:0]      putc_data,
  // getc_req: the cycle's uart_getc call; getc_data is its return value in that cycle.
  output logic            getc_req,
  input  logic [63:0]     getc_data
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = $clog2(TX_DIV + 1);
  localparam int RX_CW = $clog2(RX_POLL + 1);
  localparam logic [TX_CW-1:0] TX_RELOAD = TX_CW'(TX_DIV - 1);
  localparam logic [RX_CW-1:0] RX_RELOAD = RX_CW'(RX_POLL - 1);

  localparam logic [7:0] A_DATA = 8'h00;
  localparam logic [7:0] A_IER  = 8'h01;
  localparam logic [7:0] A_ISR  = 8'h02;
  localparam logic [7:0] A_LSR  = 8'h05;
  localparam logic [7:0] A_SCR  = 8'h07;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [TX_AW:0]   tx_wp, tx_rp;
  logic [RX_AW:0]   rx_wp, rx_rp;
  logic [TX_CW-1:0] tx_cnt;
  logic [RX_CW-1:0] rx_cnt;
  logic [1:0]       ier;
  logic [7:0]       scr;
  logic             txovf;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       thr_wr, tx_push, rbr_rd, rx_pop, rx_push, lsr_rd;
  logic       dr, rx_pend, txe_pend;
  logic [7:0] lsr, rd_byte;
  logic       getc_unused;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

  assign thr_wr  = wen && (waddr == A_DATA);
  assign tx_push = thr_wr && !tx_full;
  assign rbr_rd  = ren && (raddr == A_DATA);
  assign rx_pop  = rbr_rd && !rx_empty;
  assign lsr_rd  = ren && (raddr == A_LSR);

  assign putc_valid = resetn && (tx_cnt == '0) && !tx_empty;
  assign putc_data  = tx_mem[tx_rp[TX_AW-1:0]];

  // A same-cycle RBR pop frees a slot, so a full FIFO being drained still polls.
  assign getc_req    = resetn && (rx_cnt == '0) && (!rx_full || rx_pop);
  assign rx_push     = getc_req && !getc_data[63];
  assign getc_unused = ^getc_data[62:8];

  assign dr       = !rx_empty;
  assign rx_pend  = ier[0] & dr;
  assign txe_pend = ier[1] & tx_empty;
  assign lsr      = {1'b0, tx_empty, !tx_full, 3'b000, txovf, dr};

  always_comb begin
    // NOTE: default first so every path assigns rd_byte and no latch is inferred.
    rd_byte = 8'h00;
    case (raddr)
      A_DATA:  rd_byte = rx_empty ? 8'h00 : rx_mem[rx_rp[RX_AW-1:0]];
      A_IER:   rd_byte = {6'b0, ier};
      A_ISR:   rd_byte = {6'b0, txe_pend, rx_pend};
      A_LSR:   rd_byte = lsr;
      A_SCR:   rd_byte = scr;
      default: rd_byte = 8'h00;
    endcase
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= wdata;
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= getc_data[7:0];
  end

  // NOTE: state updates use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= TX_RELOAD;
      rx_cnt <= RX_RELOAD;
      ier    <= '0;
      scr    <= '0;
      txovf  <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
    end else begin
      if (tx_push)    tx_wp <= tx_wp + 1'b1;
      if (putc_valid) tx_rp <= tx_rp + 1'b1;
      if (rx_push)    rx_wp <= rx_wp + 1'b1;
      if (rx_pop)     rx_rp <= rx_rp + 1'b1;

      // The drain counter parks at zero while empty so the next byte leaves immediately.
      if (tx_cnt == '0) tx_cnt <= tx_empty ? '0 : TX_RELOAD;
      else              tx_cnt <= tx_cnt - 1'b1;

      if (rx_cnt == '0) rx_cnt <= RX_RELOAD;
      else              rx_cnt <= rx_cnt - 1'b1;

      if (wen && (waddr == A_IER)) ier <= wdata[1:0];
      if (wen && (waddr == A_SCR)) scr <= wdata;

      // A drop in the same cycle as an LSR read wins, so that overflow is not lost.
      if (thr_wr && tx_full) txovf <= 1'b1;
      else if (lsr_rd)       txovf <= 1'b0;

      if (ren) rdata <= {{(XLEN-8){1'b0}}, rd_byte};
      irq <= rx_pend | txe_pend;
    end
  end

endmodule

// File: tb/tb_sim_uart_fifo.sv
// Self-checking bench for sim_uart_fifo: queue-based reference model compared every cycle,
// directed register-map scenarios pinned with literal expectations, then randomized traffic.
module tb_sim_uart_fifo;
  localparam int XLEN     = 64;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int TX_DIV   = 4;
  localparam int RX_POLL  = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wen = 1'b0, ren = 1'b0;
  logic [7:0]      waddr = '0, wdata = '0, raddr = '0;
  logic [XLEN-1:0] rdata;
  logic            irq, putc_valid, getc_req;
  logic [7:0]      putc_data;
  logic [63:0]     getc_data = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  sim_uart_fifo #(
    .XLEN(XLEN), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
    .TX_DIV(TX_DIV), .RX_POLL(RX_POLL)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .irq(irq),
    .putc_valid(putc_valid), .putc_data(putc_data),
    .getc_req(getc_req), .getc_data(getc_data)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [63:0] host_q[$];
  logic [1:0]  m_ier;
  logic [7:0]  m_scr;
  logic        m_ovf;
  int          m_txc, m_rxc;
  logic [63:0] m_rdata;
  logic        m_irq;
  bit          armed = 0;
  int          txn, rxn;
  bit          pop_tx, pop_rx, poll, drop;

  function automatic logic [7:0] reg_value(input logic [7:0] a);
    case (a)
      8'h00: return (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      8'h01: return {6'b0, m_ier};
      8'h02: return {6'b0, m_ier[1] && (tx_q.size() == 0), m_ier[0] && (rx_q.size() > 0)};
      8'h05: return {1'b0, tx_q.size() == 0, tx_q.size() < TX_DEPTH, 3'b000,
                     m_ovf, rx_q.size() > 0};
      8'h07: return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      tx_q.delete();
      rx_q.delete();
      m_ier = '0; m_scr = '0; m_ovf = 1'b0;
      m_txc = TX_DIV - 1;
      m_rxc = RX_POLL - 1;
      m_rdata = '0;
      m_irq = 1'b0;
      armed = 1;
    end else if (armed) begin
      txn    = tx_q.size();
      rxn    = rx_q.size();
      pop_tx = (m_txc == 0) && (txn > 0);
      pop_rx = ren && (raddr == 8'h00) && (rxn > 0);
      poll   = (m_rxc == 0) && ((rxn < RX_DEPTH) || pop_rx);
      drop   = wen && (waddr == 8'h00) && (txn == TX_DEPTH);
      if (ren) m_rdata = {56'b0, reg_value(raddr)};
      m_irq = (m_ier[0] && rxn > 0) || (m_ier[1] && txn == 0);
      if (pop_tx) void'(tx_q.pop_front());
      if (wen && waddr == 8'h00 && !drop) tx_q.push_back(wdata);
      if (ren && raddr == 8'h05) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      if (wen && waddr == 8'h01) m_ier = wdata[1:0];
      if (wen && waddr == 8'h07) m_scr = wdata;
      if (pop_rx) void'(rx_q.pop_front());
      if (poll && !getc_data[63]) begin
        rx_q.push_back(getc_data[7:0]);
        void'(host_q.pop_front());
      end
      m_txc = (m_txc == 0) ? ((txn > 0) ? TX_DIV - 1 : 0) : m_txc - 1;
      m_rxc = (m_rxc == 0) ? RX_POLL - 1 : m_rxc - 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic exp_putc, exp_getc;
  always @(negedge clk) begin
    if (armed) begin
      exp_putc = resetn && (m_txc == 0) && (tx_q.size() > 0);
      exp_getc = resetn && (m_rxc == 0) &&
                 ((rx_q.size() < RX_DEPTH) || (ren && raddr == 8'h00 && rx_q.size() > 0));
      check("rdata", rdata, m_rdata);
      check("irq", 64'(irq), 64'(m_irq));
      check("putc_valid", 64'(putc_valid), 64'(exp_putc));
      if (exp_putc && putc_valid) check("putc_data", 64'(putc_data), 64'(tx_q[0]));
      check("getc_req", 64'(getc_req), 64'(exp_getc));
    end
  end

  // Log of what the DUT actually sent to the host, with cycle stamps.
  logic [7:0] dut_putc[$];
  int         dut_putc_cyc[$];
  int         cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (putc_valid) begin
      dut_putc.push_back(putc_data);
      dut_putc_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] host_char(input logic [7:0] ch);
    return {1'b0, 23'($urandom), 32'($urandom), ch};
  endfunction

  task automatic drive(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic r, input logic [7:0] ra);
    wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
    getc_data = (host_q.size() > 0) ? host_q[0] : {1'b1, 31'($urandom), 32'($urandom)};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    drive(1'b0, 8'h00, 8'h00, 1'b1, a);
  endtask

  function automatic logic [7:0] pick_addr();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0, 1, 2: return 8'h00;
      3:       return 8'h01;
      4:       return 8'h02;
      5:       return 8'h05;
      6:       return 8'h07;
      default: return 8'($urandom);
    endcase
  endfunction

  int   base;
  bit   got_dr;
  logic w, r;

  initial begin
    // Reset and idle register state.
    idle(2);
    resetn = 1'b1;
    idle(6);
    rd(8'h05);
    check("lsr_after_reset", rdata, 64'h60);
    rd(8'h00);
    check("rbr_empty", rdata, 64'h0);
    check("irq_after_reset", 64'(irq), 64'h0);

    // Paced drain of three back-to-back THR writes.
    base = dut_putc.size();
    wr(8'h00, 8'h41); wr(8'h00, 8'h42); wr(8'h00, 8'h43);
    idle(14);
    check("abc_count", 64'(dut_putc.size() - base), 64'd3);
    if (dut_putc.size() - base == 3) begin
      check("abc_0", 64'(dut_putc[base]),   64'h41);
      check("abc_1", 64'(dut_putc[base+1]), 64'h42);
      check("abc_2", 64'(dut_putc[base+2]), 64'h43);
      check("abc_gap_01", 64'(dut_putc_cyc[base+1] - dut_putc_cyc[base]), 64'd4);
      check("abc_gap_12", 64'(dut_putc_cyc[base+2] - dut_putc_cyc[base+1]), 64'd4);
    end
    rd(8'h05);
    check("lsr_temt_after_abc", rdata, 64'h60);

    // Overflow: six writes against a depth-4 FIFO draining every 4 cycles drop the sixth.
    base = dut_putc.size();
    for (int i = 0; i < 6; i++) wr(8'h00, 8'(8'h31 + i));
    rd(8'h05);
    check("lsr_txovf_set", rdata, 64'h22);
    rd(8'h05);
    check("lsr_txovf_cleared", rdata, 64'h20);
    idle(20);
    check("ovf_drain_count", 64'(dut_putc.size() - base), 64'd5);
    if (dut_putc.size() - base == 5) check("ovf_last_byte", 64'(dut_putc[base+4]), 64'h35);

    // Host input "hi".
    host_q.push_back(host_char(8'h68));
    host_q.push_back(host_char(8'h69));
    got_dr = 0;
    for (int i = 0; i < 16 && !got_dr; i++) begin
      rd(8'h05);
      got_dr = rdata[0];
    end
    check("rx_dr_within_16", 64'(got_dr), 64'd1);
    idle(10);
    rd(8'h00);
    check("rbr_h", rdata, 64'h68);
    rd(8'h00);
    check("rbr_i", rdata, 64'h69);
    rd(8'h05);
    check("dr_clear", 64'(rdata[0]), 64'd0);

    // Interrupt enables.
    host_q.push_back(host_char(8'h78));
    idle(10);
    wr(8'h01, 8'h01);
    idle(1);
    check("irq_rx_ready", 64'(irq), 64'd1);
    rd(8'h00);
    check("rbr_x", rdata, 64'h78);
    check("irq_hold_pop_cycle", 64'(irq), 64'd1);
    idle(1);
    check("irq_after_pop", 64'(irq), 64'd0);
    wr(8'h01, 8'h02);
    idle(1);
    check("irq_tx_empty", 64'(irq), 64'd1);
    rd(8'h02);
    check("isr_txe", rdata, 64'h02);
    wr(8'h01, 8'h00);

    // Fill RX, then pop on a poll cycle: the held fifth character enters at once.
    for (int i = 0; i < 5; i++) host_q.push_back(host_char(8'(8'h61 + i)));
    idle(45);
    for (int i = 0; i < RX_POLL && m_rxc != 0; i++) idle(1);
    for (int i = 0; i < 5; i++) begin
      rd(8'h00);
      check("rx_full_pop", rdata, 64'(8'h61 + i));
    end
    rd(8'h00);
    check("rx_drained", rdata, 64'h0);

    // Reset in the middle of a drain.
    host_q.push_back(host_char(8'h7a));
    idle(10);
    wr(8'h01, 8'h01);
    wr(8'h07, 8'h5a);
    rd(8'h07);
    check("scr_readback", rdata, 64'h5a);
    check("irq_before_reset", 64'(irq), 64'd1);
    wr(8'h00, 8'h51); wr(8'h00, 8'h52); wr(8'h00, 8'h53);
    idle(3);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    base = dut_putc.size();
    check("rdata_after_reset", rdata, 64'h0);
    check("irq_after_midreset", 64'(irq), 64'd0);
    idle(20);
    check("no_putc_after_reset", 64'(dut_putc.size() - base), 64'd0);
    rd(8'h07);
    check("scr_after_reset", rdata, 64'h0);
    rd(8'h05);
    check("lsr_after_midreset", rdata, 64'h60);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0 && host_q.size() < 8) host_q.push_back(host_char(8'($urandom)));
      if ($urandom_range(0, 599) == 0) begin
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
      end
      w = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 9) < 4);
      drive(w, pick_addr(), 8'($urandom), r, pick_addr());
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
